// File: rtl/register_arbiter_pkg.sv
// rtl/register_arbiter_pkg.sv - shared types and constants for the register-file arbiter
package register_arbiter_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NREQ_MAX     = 8;
    localparam int TAG_IW       = idx_width(NREQ_MAX);
    localparam int READ_LATENCY = 1;
    // One stage covers the issue register, the rest cover the register-file read latency.
    localparam int TAG_STAGES   = READ_LATENCY + 1;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [TAG_IW-1:0] id;
    } tag_t;

endpackage

// File: rtl/register_arbiter_rr_arbiter.sv
// rtl/register_arbiter_rr_arbiter.sv - combinational round-robin grant from an external pointer
module rr_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic found;

    // First pass searches ptr..NREQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (IW'(j) >= ptr)) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (IW'(j) < ptr)) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/register_arbiter.sv
// rtl/register_arbiter.sv - round-robin sharing of a single-ported register file among requesters
module register_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int NREQ  = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int IW = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  m_w_en,
    output logic                  m_r_en,
    output logic [AW-1:0]         m_addr,
    output logic [WIDTH-1:0]      m_wdata,
    input  logic [WIDTH-1:0]      m_r_value,
    input  logic                  m_r_valid
);

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    ptr;
    logic             accept;
    logic             sel_write;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    tag_t             tag_q [TAG_STAGES];
    tag_t             rsp_tag;
    logic             rsp_fire;
    logic             proto_err;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = reset ? '0 : grant;
    assign accept    = |req_ready;

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
        end
    end

    // Address/data hold their last value when idle; write data only moves on writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_w_en  <= 1'b0;
            m_r_en  <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            m_w_en <= accept & sel_write;
            m_r_en <= accept & ~sel_write;
            if (accept) begin
                m_addr <= sel_addr;
                if (sel_write) begin
                    m_wdata <= sel_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < TAG_STAGES; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: accept, write: sel_write, id: TAG_IW'(gidx)};
            for (int s = 1; s < TAG_STAGES; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign rsp_tag  = tag_q[TAG_STAGES-1];
    assign rsp_fire = rsp_tag.valid & (rsp_tag.write | m_r_valid) & ~reset;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_fire && (rsp_tag.id == TAG_IW'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_rdata = (rsp_fire & ~rsp_tag.write) ? m_r_value : '0;

    // A read tag arriving without the read strobe means the register file broke its latency contract.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (rsp_tag.valid && !rsp_tag.write && !m_r_valid) begin
            proto_err <= 1'b1;
        end else begin
            proto_err <= proto_err;
        end
    end

endmodule

// File: tb/tb_register_arbiter.sv
// tb/tb_register_arbiter.sv - directed vectors plus scoreboarded random traffic for register_arbiter
module tb_register_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int NREQ  = 4;
    localparam int AW    = 5;
    localparam int NCYC  = 10000;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  m_w_en;
    logic                  m_r_en;
    logic [AW-1:0]         m_addr;
    logic [WIDTH-1:0]      m_wdata;
    logic [WIDTH-1:0]      m_r_value;
    logic                  m_r_valid;

    register_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .m_w_en    (m_w_en),
        .m_r_en    (m_r_en),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_r_value (m_r_value),
        .m_r_valid (m_r_valid)
    );

    always #5 clk = ~clk;

    // Register-file model: 1-cycle registered read with a valid strobe.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        m_r_valid <= m_r_en;
        if (m_r_en) m_r_value <= mem[m_addr];
        if (m_w_en) mem[m_addr] <= m_wdata;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [3:0]  rdy;
        logic        we;
        logic        re;
        logic [4:0]  maddr;
        logic [3:0]  rsp;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] w, logic [4:0] a, logic [15:0] d,
                                logic [3:0] r, logic we, logic re, logic [4:0] ma,
                                logic [3:0] rs, logic [15:0] rd);
        vec_t t;
        t.valid = v; t.write = w; t.addr = a; t.wdata = d;
        t.rdy = r; t.we = we; t.re = re; t.maddr = ma; t.rsp = rs; t.rdata = rd;
        return t;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [4:0] a, input logic [15:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = {NREQ{a}};
        req_wdata = {NREQ{d}};
    endtask

    typedef struct {
        int          id;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t             sb[$];
    logic [15:0]      ref_mem [DEPTH];
    logic [NREQ-1:0]  pend;
    logic             cw [NREQ];
    logic [AW-1:0]    ca [NREQ];
    logic [WIDTH-1:0] cd [NREQ];
    int               waitc [NREQ];
    int               max_wait;

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'(a * 257);
        mem[5] = 16'hBEEF;
        mem[7] = 16'h0000;
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 5'd0, 16'h0);

        // Reset state, with all requesters asking
        repeat (3) @(posedge clk);
        #1 drive(4'b1111, 4'b0000, 5'd3, 16'hAAAA);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp", 32'(rsp_valid), 32'h0);
        chk("rst_wen", 32'(m_w_en), 32'h0);
        chk("rst_ren", 32'(m_r_en), 32'h0);
        chk("rst_addr", 32'(m_addr), 32'h0);
        chk("rst_wdata", 32'(m_wdata), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed cycle table: single read, write-then-read, full rotation, lone requester wrap
        vecs.push_back(mk(4'b0100, 4'b0000, 5, 16'h0,    4'b0100, 0, 0, 0, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 1, 5, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 0, 0, 4'b0100, 16'hBEEF));
        vecs.push_back(mk(4'b0010, 4'b0010, 7, 16'h1234, 4'b0010, 0, 0, 0, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b1000, 4'b0000, 7, 16'h0,    4'b1000, 1, 0, 7, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 1, 7, 4'b0010, 16'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 0, 0, 4'b1000, 16'h1234));
        vecs.push_back(mk(4'b1111, 4'b0000, 5, 16'h0,    4'b0001, 0, 0, 0, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b1111, 4'b0000, 5, 16'h0,    4'b0010, 0, 1, 5, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b1111, 4'b0000, 5, 16'h0,    4'b0100, 0, 1, 5, 4'b0001, 16'hBEEF));
        vecs.push_back(mk(4'b1111, 4'b0000, 5, 16'h0,    4'b1000, 0, 1, 5, 4'b0010, 16'hBEEF));
        vecs.push_back(mk(4'b1111, 4'b0000, 5, 16'h0,    4'b0001, 0, 1, 5, 4'b0100, 16'hBEEF));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 1, 5, 4'b1000, 16'hBEEF));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 0, 0, 4'b0001, 16'hBEEF));
        vecs.push_back(mk(4'b1000, 4'b1000, 9, 16'h5555, 4'b1000, 0, 0, 0, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b1000, 4'b1000, 9, 16'h5555, 4'b1000, 1, 0, 9, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b1000, 4'b1000, 9, 16'h5555, 4'b1000, 1, 0, 9, 4'b1000, 16'h0));
        vecs.push_back(mk(4'b1000, 4'b1000, 9, 16'h5555, 4'b1000, 1, 0, 9, 4'b1000, 16'h0));
        vecs.push_back(mk(4'b1000, 4'b1000, 9, 16'h5555, 4'b1000, 1, 0, 9, 4'b1000, 16'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 1, 0, 9, 4'b1000, 16'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 0, 0, 4'b1000, 16'h0));
        vecs.push_back(mk(4'b0011, 4'b0000, 9, 16'h0,    4'b0001, 0, 0, 0, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b0010, 4'b0000, 9, 16'h0,    4'b0010, 0, 1, 9, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 1, 9, 4'b0001, 16'h5555));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 16'h0,    4'b0000, 0, 0, 0, 4'b0010, 16'h5555));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].valid, vecs[k].write, vecs[k].addr, vecs[k].wdata);
            @(negedge clk);
            chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].rdy));
            chk($sformatf("v%0d_wen", k), 32'(m_w_en), 32'(vecs[k].we));
            chk($sformatf("v%0d_ren", k), 32'(m_r_en), 32'(vecs[k].re));
            chk($sformatf("v%0d_rsp", k), 32'(rsp_valid), 32'(vecs[k].rsp));
            chk($sformatf("v%0d_rdata", k), 32'(rsp_rdata), 32'(vecs[k].rdata));
            if (vecs[k].we || vecs[k].re)
                chk($sformatf("v%0d_maddr", k), 32'(m_addr), 32'(vecs[k].maddr));
            if (vecs[k].we && k > 0)
                chk($sformatf("v%0d_mwdata", k), 32'(m_wdata), 32'(vecs[k-1].wdata));
            @(posedge clk);
            #1;
        end

        // Reset one cycle after a read is accepted (ptr is 2 here)
        drive(4'b0100, 4'b0000, 5'd5, 16'h0);
        @(negedge clk);
        chk("mid_accept", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(4'b0000, 4'b0000, 5'd0, 16'h0);
        @(negedge clk);
        chk("mid_rst1_ready", 32'(req_ready), 32'h0);
        chk("mid_rst1_rsp", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1 drive(4'b1111, 4'b0000, 5'd5, 16'h0);
        @(negedge clk);
        chk("mid_rst2_ready", 32'(req_ready), 32'h0);
        chk("mid_rst2_rsp", 32'(rsp_valid), 32'h0);
        chk("mid_rst2_ren", 32'(m_r_en), 32'h0);
        chk("mid_rst2_wen", 32'(m_w_en), 32'h0);
        chk("mid_rst2_addr", 32'(m_addr), 32'h0);
        chk("mid_rst2_wdata", 32'(m_wdata), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(4'b0000, 4'b0000, 5'd0, 16'h0);
        @(negedge clk);
        chk("post_rst_rsp0", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1 drive(4'b1111, 4'b0000, 5'd5, 16'h0);
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        chk("post_rst_rsp1", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1 drive(4'b0000, 4'b0000, 5'd0, 16'h0);
        @(negedge clk);
        chk("post_rst_rsp2", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_rsp3", 32'(rsp_valid), 32'h1);
        chk("post_rst_rdata3", 32'(rsp_rdata), 32'hBEEF);
        repeat (3) @(posedge clk);
        #1;

        // Random mixed traffic against a reference memory and response scoreboard
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = mem[a];
        pend = '0;
        max_wait = 0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < NCYC + 6; cyc++) begin
            logic [NREQ-1:0] acc;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && cyc < NCYC && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    cw[i] = 1'($urandom_range(0, 1));
                    ca[i] = AW'($urandom_range(0, DEPTH - 1));
                    cd[i] = WIDTH'($urandom);
                end
                req_write[i] = cw[i];
                req_addr[i*AW +: AW] = ca[i];
                req_wdata[i*WIDTH +: WIDTH] = cd[i];
            end
            req_valid = pend;
            @(negedge clk);
            if (rsp_valid != '0) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_rsp_extra: got rsp_valid %b at cycle %0d with none expected", rsp_valid, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp_valid !== 4'(1 << e.id) || rsp_rdata !== e.data || cyc != e.due) begin
                        fails++;
                        $display("FAIL rnd_rsp: got rsp_valid %b rdata %h cycle %0d expected %b %h cycle %0d",
                                 rsp_valid, rsp_rdata, cyc, 4'(1 << e.id), e.data, e.due);
                    end
                end
            end
            acc = req_ready & req_valid;
            if (req_valid != '0) begin
                tests++;
                if (!$onehot(acc)) begin
                    fails++;
                    $display("FAIL rnd_grant: got accept %b for valid %b at cycle %0d expected one-hot", acc, req_valid, cyc);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    exp_t e;
                    e.id = i;
                    e.due = cyc + 2;
                    if (cw[i]) begin
                        ref_mem[ca[i]] = cd[i];
                        e.data = '0;
                    end else begin
                        e.data = ref_mem[ca[i]];
                    end
                    sb.push_back(e);
                    if (waitc[i] > max_wait) max_wait = waitc[i];
                    waitc[i] = 0;
                    pend[i] = 1'b0;
                end else if (pend[i] && acc != '0) begin
                    waitc[i]++;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_drain", 32'(sb.size()), 32'h0);
        tests++;
        if (max_wait > NREQ - 1) begin
            fails++;
            $display("FAIL rnd_max_wait: got %0d grants waited, required at most %0d", max_wait, NREQ - 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_arbiter.md
# register_arbiter

Round-robin arbiter that shares one single-ported register file (one write or one read per cycle, 1-cycle registered read latency, read-valid strobe) among NREQ independent requesters. Each requester issues read/write commands over a valid/ready handshake and receives exactly one response pulse per accepted command. The arbiter sits between the control-plane masters and the register file, owns all of its enable/address/data inputs, and routes its read data back to the originating requester.

## Interface
- WIDTH, 16: register data width.
- DEPTH, 32: number of registers; AW = $clog2(DEPTH).
- NREQ, 4: number of requesters (2..8); IW = $clog2(NREQ).

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW].
- req_wdata  in  NREQ*WIDTH  packed write data.
- rsp_valid  out  NREQ  one-cycle response pulse to requester i; no backpressure.
- rsp_rdata  out  WIDTH  read data, shared by all requesters, qualified by rsp_valid.
- m_w_en, m_r_en  out  1 each  register-file write/read enables; never both high.
- m_addr  out  AW  register-file address (drives both write and read address).
- m_wdata  out  WIDTH  register-file write data.
- m_r_value  in  WIDTH  register-file read data.
- m_r_valid  in  1  register-file read-valid strobe.

## Operation
- Grant: combinational round-robin over req_valid from pointer ptr. The lowest index i ≥ ptr with req_valid[i] wins, wrapping to 0. req_ready = grant; all zero during reset.
- Accept when req_valid[i] & req_ready[i]. Then ptr <= (i+1) mod NREQ. ptr is unchanged when nothing is accepted.
- Requesters hold valid/write/addr/wdata stable until accepted. The arbiter never drops a valid request, and each requester waits at most NREQ-1 grants.
- Issue stage (registered): the accepted command drives m_w_en or m_r_en plus m_addr/m_wdata for exactly one cycle. When idle, enables are 0 and addr/wdata hold their last value.
- Tag pipeline: a 2-stage shift register of {valid, id[IW], write} travels alongside each command.
- Response:
  - Read: rsp_valid[id] = m_r_valid and rsp_rdata = m_r_value.
  - Write: rsp_valid[id] is pulsed internally and rsp_rdata = 0.
- A read whose tag is valid but lacks m_r_valid is a protocol error. It sets a sticky internal flag and produces no response.
- Ordering: commands execute in acceptance order. A read accepted one cycle after a write to the same address returns the new value.
- Reset: ptr=0; issue and tag stages cleared; req_ready=0, rsp_valid=0, m_w_en=0, m_r_en=0, m_addr=0, m_wdata=0.
- Reset mid-operation: in-flight commands are discarded with no response, and no rsp_valid is produced on the cycle after reset deasserts.

## Timing
- Accept at cycle T → register-file enable at T+1 → rsp_valid at T+2 (read and write alike).
- Throughput: one command per cycle sustained, back-to-back across requesters or from the same requester.
- At most one rsp_valid bit high per cycle.
- Simultaneous requests resolve in the same cycle they are presented; there is no idle arbitration cycle.

## Structure
- Package register_arbiter_pkg:
  - typedef tag_t {logic valid; logic write; logic [IW-1:0] id;} with IW from a package function.
  - localparam for the read latency (1), used to size the tag pipeline.
- Sub-module rr_arbiter (#NREQ): inputs req and ptr, outputs a one-hot grant and the encoded index. It is combinational and owns no state; ptr lives in register_arbiter.
- Top-level: grant/ptr logic, issue register, tag pipeline, response demux.

## Test plan
- Single read, NREQ=4, requester 2 reads addr 5 preloaded with 0xBEEF. Accept at T, m_r_en at T+1 with m_addr=5, rsp_valid=4'b0100 and rsp_rdata=0xBEEF at T+2.
- All four requesters valid continuously from ptr=0. Grants go 0,1,2,3,0,… one per cycle, and responses arrive in the same order two cycles after each grant.
- Requester 1 writes 0x1234 to addr 7 at T and requester 3 reads addr 7 at T+1. The read returns 0x1234; the write ack is rsp_valid[1] at T+2 with rsp_rdata=0.
- Only requester 3 valid for 5 cycles with ptr=1. Every cycle is granted (wrap search), and ptr settles at 0.
- Reset asserted one cycle after a read is accepted. No rsp_valid at any later cycle, all outputs 0 during reset, and the first post-reset grant goes to requester 0.
- Random mixed read/write traffic, 10k cycles, checked against a scoreboard. Exactly one response per accept, correct id routing, data matching a reference memory, and a maximum wait of NREQ-1 grants.
